// File: rtl/switch_debounce_pair.sv
// Two-flop synchronizer plus shared debounce for two switch banks.
// Both banks settle as a single vector so s1/s2 always update on the same edge.
module switch_debounce_pair #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DB_CYCLES = 2000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw1,
  input  logic [WIDTH-1:0] sw2,
  output logic [WIDTH-1:0] s1,
  output logic [WIDTH-1:0] s2,
  output logic             changed,
  output logic             settling
);

  localparam int unsigned VW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic [VW-1:0]    sync_a;
  logic [VW-1:0]    raw;
  logic [VW-1:0]    cand;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_a  <= '0;
      raw     <= '0;
      cand    <= '0;
      cnt     <= '0;
      s1      <= '0;
      s2      <= '0;
      changed <= 1'b0;
    end else begin
      sync_a  <= {sw1, sw2};
      raw     <= sync_a;
      changed <= 1'b0;
      if (raw != cand) begin
        // Any movement of the synchronized value restarts the settle window.
        cand <= raw;
        cnt  <= '0;
      end else if (cnt == CNT_LAST) begin
        // Counter saturates here; acceptance only when the candidate is new.
        if (cand != {s1, s2}) begin
          s1      <= cand[VW-1:WIDTH];
          s2      <= cand[WIDTH-1:0];
          changed <= 1'b1;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    settling = (cand != {s1, s2});
  end

endmodule

// File: tb/tb_switch_debounce_pair.sv
// Directed and randomized checks of switch_debounce_pair against a
// sample-history reference model (accept when DB_CYCLES+1 samples agree).
module tb_switch_debounce_pair;

  localparam int unsigned DB = 4;
  localparam int unsigned HN = DB + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] sw1 = '0;
  logic [3:0] sw2 = '0;
  logic [3:0] s1;
  logic [3:0] s2;
  logic       changed;
  logic       settling;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;

  logic [7:0] hist[$];
  logic [7:0] m_stable = '0;
  logic       m_changed = 1'b0;
  logic       m_settling = 1'b0;

  switch_debounce_pair #(.WIDTH(4), .DB_CYCLES(DB), .CNT_W(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .sw1      (sw1),
    .sw2      (sw2),
    .s1       (s1),
    .s2       (s2),
    .changed  (changed),
    .settling (settling)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Reference: the value sampled at edge t reaches the candidate at t+2; a
  // value is accepted at edge t when samples t-DB-2 .. t-2 all agree and
  // differ from the current stable value. Reset makes all history zero.
  task automatic model_edge(input logic rst_n, input logic [7:0] smp);
    bit all_eq;
    if (!rst_n) begin
      hist.delete();
      for (int i = 0; i < HN; i++) hist.push_back('0);
      m_stable  = '0;
      m_changed = 1'b0;
    end else begin
      hist.push_back(smp);
      void'(hist.pop_front());
      all_eq = 1'b1;
      for (int i = 1; i <= DB; i++) if (hist[i] != hist[0]) all_eq = 1'b0;
      if (all_eq && hist[0] != m_stable) begin
        m_stable  = hist[0];
        m_changed = 1'b1;
      end else begin
        m_changed = 1'b0;
      end
    end
    m_settling = (hist[DB] != m_stable);
  endtask

  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic r);
    @(negedge clk);
    sw1   = a;
    sw2   = b;
    reset = r;
    @(posedge clk);
    edge_n++;
    model_edge(r, {a, b});
    #1;
    check("s1", int'(s1), int'(m_stable[7:4]));
    check("s2", int'(s2), int'(m_stable[3:0]));
    check("changed", int'(changed), int'(m_changed));
    check("settling", int'(settling), int'(m_settling));
  endtask

  task automatic hold(input logic [3:0] a, input logic [3:0] b, input int n,
                      output int acc, output int pulses);
    acc    = -1;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      step(a, b, 1'b1);
      if (changed === 1'b1) pulses++;
      if (acc < 0 && {s1, s2} === {a, b}) acc = edge_n;
    end
  endtask

  initial begin
    int e, acc, pulses, last;

    for (int i = 0; i < HN; i++) hist.push_back('0);

    // 1: reset with F/A held, then full-latency acceptance
    step(4'hF, 4'hA, 1'b0);
    step(4'hF, 4'hA, 1'b0);
    check("rst_s1", int'(s1), 0);
    check("rst_s2", int'(s2), 0);
    check("rst_changed", int'(changed), 0);
    check("rst_settling", int'(settling), 0);
    e = edge_n + 1;
    hold(4'hF, 4'hA, 10, acc, pulses);
    check("t1_latency", acc - e, 6);
    check("t1_pulses", pulses, 1);

    // 2: single-bank change
    hold(4'h3, 4'h5, 10, acc, pulses);
    e = edge_n + 1;
    hold(4'h9, 4'h5, 10, acc, pulses);
    check("t2_latency", acc - e, 6);
    check("t2_pulses", pulses, 1);

    // 3: bounce restarts the window
    hold(4'h3, 4'h5, 10, acc, pulses);
    step(4'h9, 4'h5, 1'b1);
    step(4'h3, 4'h5, 1'b1);
    step(4'h9, 4'h5, 1'b1);
    last = edge_n;
    hold(4'h9, 4'h5, 10, acc, pulses);
    check("t3_latency", acc - last, 6);
    check("t3_pulses", pulses, 1);

    // 4: one-cycle glitch on bank 2 never accepted
    hold(4'h9, 4'h0, 10, acc, pulses);
    step(4'h9, 4'h7, 1'b1);
    hold(4'h9, 4'h0, 10, acc, pulses);
    check("t4_pulses", pulses, 0);
    check("t4_s2", int'(s2), 0);

    // 5: both banks change together
    hold(4'h2, 4'h1, 10, acc, pulses);
    e = edge_n + 1;
    hold(4'hC, 4'hE, 10, acc, pulses);
    check("t5_latency", acc - e, 6);
    check("t5_pulses", pulses, 1);

    // 6: reset two edges before acceptance
    for (int i = 0; i < 4; i++) step(4'h5, 4'h6, 1'b1);
    step(4'h5, 4'h6, 1'b0);
    step(4'h5, 4'h6, 1'b0);
    check("t6_s1", int'(s1), 0);
    check("t6_s2", int'(s2), 0);
    check("t6_changed", int'(changed), 0);
    e = edge_n + 1;
    hold(4'h5, 4'h6, 10, acc, pulses);
    check("t6_latency", acc - e, 6);
    check("t6_pulses", pulses, 1);

    // Randomized bursts of bounce and holds, with occasional resets
    for (int k = 0; k < 300; k++) begin
      logic [3:0] ra, rb;
      int len;
      ra  = 4'($urandom);
      rb  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : sw2;
      len = int'($urandom_range(1, 8));
      if ($urandom_range(0, 39) == 0) begin
        step(ra, rb, 1'b0);
      end else begin
        for (int j = 0; j < len; j++) step(ra, rb, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
